// File: rtl/pwm_sample_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pwm_sample_decoder
// Purpose  : Recovers samples from a single-pin PWM stream by measuring the
//            high time of each 2**WIDTH-clock frame, aligned on rising edges.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_sample_decoder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             pwm_i,
    output logic [WIDTH-1:0] sample_o,
    output logic             valid_o,
    output logic             locked_o,
    output logic             err_o
);

    localparam int PERIOD = 2 ** WIDTH;

    localparam logic [0:0]       c_st_unlocked = 1'b0;
    localparam logic [0:0]       c_st_locked   = 1'b1;
    localparam logic [WIDTH-1:0] c_fc_last     = WIDTH'(PERIOD - 1);
    localparam logic [WIDTH:0]   c_hc_full     = (WIDTH + 1)'(PERIOD);

    logic             sync1_q;
    logic             s_q;
    logic             s_d_q;
    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] fc_q, fc_d;
    logic [WIDTH:0]   hc_q, hc_d;
    logic [WIDTH-1:0] sample_q, sample_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;

    logic             w_rise;
    logic [WIDTH:0]   w_hc_sum;

    assign w_rise   = s_q & ~s_d_q;
    assign w_hc_sum = hc_q + (WIDTH + 1)'(s_q);

    // The synchronizer is clocked regardless of en so the edge detector is
    // already settled when the decoder is re-enabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            s_q      <= 1'b0;
            s_d_q    <= 1'b0;
            state_q  <= c_st_unlocked;
            fc_q     <= '0;
            hc_q     <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sync1_q  <= pwm_i;
            s_q      <= sync1_q;
            s_d_q    <= s_q;
            state_q  <= state_d;
            fc_q     <= fc_d;
            hc_q     <= hc_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fc_d     = fc_q;
        hc_d     = hc_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        if (!en) begin
            state_d = c_st_unlocked;
            fc_d    = '0;
            hc_d    = '0;
        end else begin
            case (state_q)
                c_st_unlocked: begin
                    // The locking edge is position 0 of the frame and is high.
                    if (w_rise) begin
                        state_d = c_st_locked;
                        fc_d    = WIDTH'(1);
                        hc_d    = (WIDTH + 1)'(1);
                    end
                end
                c_st_locked: begin
                    if (w_rise && (fc_q != '0)) begin
                        err_d = 1'b1;
                        fc_d  = WIDTH'(1);
                        hc_d  = (WIDTH + 1)'(1);
                    end else if (fc_q == c_fc_last) begin
                        valid_d = 1'b1;
                        fc_d    = '0;
                        hc_d    = '0;
                        // A frame high throughout cannot be represented.
                        if (w_hc_sum == c_hc_full) begin
                            sample_d = c_fc_last;
                            err_d    = 1'b1;
                        end else begin
                            sample_d = w_hc_sum[WIDTH-1:0];
                        end
                    end else begin
                        fc_d = fc_q + WIDTH'(1);
                        hc_d = w_hc_sum;
                    end
                end
                default: begin
                    state_d = c_st_unlocked;
                    fc_d    = '0;
                    hc_d    = '0;
                end
            endcase
        end
    end

    always_comb begin
        sample_o = sample_q;
        valid_o  = valid_q;
        err_o    = err_q;
        locked_o = (state_q == c_st_locked);
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_sample_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_sample_decoder
// Purpose  : Randomized and directed stimulus for pwm_sample_decoder, checked
//            every cycle against a frame-window reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_sample_decoder;

    localparam int W = 4;
    localparam int P = 2 ** W;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         pwm;
    logic [W-1:0] sample;
    logic         valid;
    logic         locked;
    logic         err;

    int checks = 0;
    int errors = 0;

    // Reference model state: pin history and the s values of the open frame.
    bit p1, p2, p3;
    bit m_locked;
    int win[$];
    int m_sample;
    bit m_valid;
    bit m_err;

    pwm_sample_decoder #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .pwm_i    (pwm),
        .sample_o (sample),
        .valid_o  (valid),
        .locked_o (locked),
        .err_o    (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        p1 = 0; p2 = 0; p3 = 0;
        m_locked = 0;
        win.delete();
        m_sample = 0;
        m_valid  = 0;
        m_err    = 0;
    endtask

    task automatic model_edge(input bit pin_v, input bit en_v);
        bit s, sd, rise;
        int cnt;
        s = p2;
        sd = p3;
        rise = s && !sd;
        p3 = p2; p2 = p1; p1 = pin_v;
        m_valid = 0;
        m_err   = 0;
        if (!en_v) begin
            m_locked = 0;
            win.delete();
        end else if (!m_locked) begin
            if (rise) begin
                m_locked = 1;
                win.delete();
                win.push_back(1);
            end
        end else if (rise && win.size() != 0) begin
            m_err = 1;
            win.delete();
            win.push_back(1);
        end else begin
            win.push_back(int'(s));
            if (win.size() == P) begin
                cnt = 0;
                foreach (win[k]) cnt += win[k];
                m_valid = 1;
                if (cnt == P) begin
                    m_sample = P - 1;
                    m_err    = 1;
                end else begin
                    m_sample = cnt;
                end
                win.delete();
            end
        end
    endtask

    task automatic compare_all();
        chk("sample", 32'(sample), 32'(m_sample));
        chk("valid",  32'(valid),  32'(m_valid));
        chk("locked", 32'(locked), 32'(m_locked));
        chk("err",    32'(err),    32'(m_err));
    endtask

    task automatic step(input bit p, input bit e);
        @(negedge clk);
        pwm = p;
        en  = e;
        @(posedge clk);
        if (reset) model_reset();
        else       model_edge(p, e);
        #1;
        compare_all();
    endtask

    task automatic frame(input int n);
        for (int i = 0; i < P; i++) step(i < n, 1'b1);
    endtask

    initial begin
        int n;
        int gpos;
        reset = 1'b1;
        en    = 1'b0;
        pwm   = 1'b0;
        model_reset();
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        reset = 1'b0;

        repeat (3) step(1'b0, 1'b1);
        repeat (3) frame(5);
        frame(9);
        frame(0);
        frame(1);
        frame(P);
        frame(3);

        // Extra rising edge at position 7; transmitter then realigns to it.
        for (int i = 0; i < 7 + P; i++) step((i < 3) || (i >= 7 && i < 11), 1'b1);
        frame(6);

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 8; i++) step(i < 12, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        pwm   = 1'b0;
        #1;
        model_reset();
        compare_all();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        reset = 1'b0;
        repeat (5) step(1'b0, 1'b1);
        frame(7);
        frame(2);

        // Enable dropped for five cycles while locked.
        for (int i = 0; i < 6; i++)  step(i < 10, 1'b1);
        for (int i = 6; i < 11; i++) step(i < 10, 1'b0);
        for (int i = 11; i < P; i++) step(1'b0, 1'b1);
        frame(4);
        frame(11);

        // Random frames, occasionally with a flipped pin position.
        repeat (30) begin
            n    = int'($urandom_range(0, P));
            gpos = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, P - 1)) : -1;
            for (int i = 0; i < P; i++) step((i < n) ^ (i == gpos), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
